// File: rtl/alu_compare_sequencer.sv
// -----------------------------------------------------------------------------
// alu_compare_sequencer
//
// Drives one operand/opcode stream into two WIDTH-bit ALUs in lockstep. One is
// the reference ALU and the other is the device under test. After each vector
// has settled, the block compares the two results and zero flags. It logs the
// mismatch count and the first failing vector. Vectors come either from an
// exhaustive sweep of {op, a, b} or from a 32-bit Galois LFSR.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start              begin a run (sampled only while idle)
//   abort              terminate a run (sampled in APPLY/SETTLE/CHECK)
//   mode_exh           1 = exhaustive sweep, 0 = LFSR random (latched at start)
//   stop_on_mismatch   end the run at the first mismatch (latched at start)
//   num_vectors        random-mode vector count (latched at start)
//   vec_a/vec_b/vec_op vector driven to both ALUs
//   y_ref/zero_ref     reference ALU outputs
//   y_dut/zero_dut     DUT ALU outputs
//   busy               high in APPLY, SETTLE, CHECK and DONE
//   done               one-cycle pulse in DONE
//   vec_index          index of the vector currently applied
//   mismatch_flag      sticky mismatch indicator for this run
//   mismatch_count     saturating mismatch counter for this run
//   first_fail_*       vector of the first mismatch
// -----------------------------------------------------------------------------
module alu_compare_sequencer #(
    parameter int          WIDTH         = 8,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [31:0] LFSR_SEED     = 32'hACE1_2F3D
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 mode_exh,
    input  logic                 stop_on_mismatch,
    input  logic [15:0]          num_vectors,
    output logic [WIDTH-1:0]     vec_a,
    output logic [WIDTH-1:0]     vec_b,
    output logic [1:0]           vec_op,
    input  logic [WIDTH-1:0]     y_ref,
    input  logic                 zero_ref,
    input  logic [WIDTH-1:0]     y_dut,
    input  logic                 zero_dut,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH+1:0]   vec_index,
    output logic                 mismatch_flag,
    output logic [15:0]          mismatch_count,
    output logic [WIDTH-1:0]     first_fail_a,
    output logic [WIDTH-1:0]     first_fail_b,
    output logic [1:0]           first_fail_op
);

    localparam int IW = 2 * WIDTH + 2;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    // Galois mask for x^32 + x^22 + x^2 + x + 1 in right-shift form.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // One Galois step: shift right and fold the tap mask back in when bit 0 was set.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

    // Map an LFSR state onto the packed {op, a, b} vector layout.
    function automatic logic [IW-1:0] lfsr_vector(input logic [31:0] s);
        return {s[31:30], s[WIDTH-1:0], s[2*WIDTH-1:WIDTH]};
    endfunction

    // Vectors and first-fail captures are kept packed as {op, a, b}. In
    // exhaustive mode this layout is exactly the vector index.
    state_t          state_r,      state_s;
    logic [SW-1:0]   settle_cnt_r, settle_cnt_s;
    logic [31:0]     lfsr_r,       lfsr_s;
    logic            mode_exh_r,   mode_exh_s;
    logic            stop_r,       stop_s;
    logic [15:0]     num_vec_r,    num_vec_s;
    logic [IW-1:0]   vec_index_r,  vec_index_s;
    logic [IW-1:0]   vec_r,        vec_s;
    logic            flag_r,       flag_s;
    logic [15:0]     count_r,      count_s;
    logic [IW-1:0]   ff_r,         ff_s;
    logic            busy_r,       busy_s;
    logic            done_r,       done_s;

    logic            mismatch_s;
    logic            last_s;
    logic [31:0]     lfsr_adv_s;
    logic [IW-1:0]   idx_inc_s;
    logic [31:0]     idx_ext_s;
    logic [31:0]     num_m1_s;

    assign mismatch_s = (y_ref != y_dut) || (zero_ref != zero_dut);
    assign lfsr_adv_s = lfsr_step(lfsr_r);
    assign idx_inc_s  = vec_index_r + IW'(1);
    assign idx_ext_s  = 32'(vec_index_r);
    assign num_m1_s   = {16'h0000, num_vec_r} - 32'd1;
    // Random runs with num_vectors = 0 never reach CHECK, so num_m1_s cannot wrap here.
    assign last_s     = mode_exh_r ? (&vec_index_r) : (idx_ext_s == num_m1_s);

    // Next-state and datapath update for the run sequencer.
    always_comb begin
        state_s      = state_r;
        settle_cnt_s = settle_cnt_r;
        lfsr_s       = lfsr_r;
        mode_exh_s   = mode_exh_r;
        stop_s       = stop_r;
        num_vec_s    = num_vec_r;
        vec_index_s  = vec_index_r;
        vec_s        = vec_r;
        flag_s       = flag_r;
        count_s      = count_r;
        ff_s         = ff_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    mode_exh_s  = mode_exh;
                    stop_s      = stop_on_mismatch;
                    num_vec_s   = num_vectors;
                    flag_s      = 1'b0;
                    count_s     = 16'h0000;
                    ff_s        = {IW{1'b0}};
                    vec_index_s = {IW{1'b0}};
                    lfsr_s      = LFSR_SEED;
                    if (!mode_exh && (num_vectors == 16'h0000)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_APPLY;
                        vec_s   = mode_exh ? {IW{1'b0}} : lfsr_vector(LFSR_SEED);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s      = ST_SETTLE;
                    settle_cnt_s = {SW{1'b0}};
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (settle_cnt_r == SETTLE_LAST) begin
                    state_s = ST_CHECK;
                end else begin
                    settle_cnt_s = settle_cnt_r + SW'(1);
                end
            end
            ST_CHECK: begin
                // Abort discards this cycle's comparison entirely.
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    if (mismatch_s) begin
                        flag_s  = 1'b1;
                        count_s = (count_r == 16'hFFFF) ? 16'hFFFF : (count_r + 16'h0001);
                        if (!flag_r) begin
                            ff_s = vec_r;
                        end else begin
                            ff_s = ff_r;
                        end
                    end else begin
                        flag_s = flag_r;
                    end
                    if (last_s || (stop_r && mismatch_s)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s     = ST_APPLY;
                        vec_index_s = idx_inc_s;
                        lfsr_s      = lfsr_adv_s;
                        vec_s       = mode_exh_r ? idx_inc_s : lfsr_vector(lfsr_adv_s);
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they align with it.
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // State and datapath registers; reset clears all outputs and reloads the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= {SW{1'b0}};
            lfsr_r       <= LFSR_SEED;
            mode_exh_r   <= 1'b0;
            stop_r       <= 1'b0;
            num_vec_r    <= 16'h0000;
            vec_index_r  <= {IW{1'b0}};
            vec_r        <= {IW{1'b0}};
            flag_r       <= 1'b0;
            count_r      <= 16'h0000;
            ff_r         <= {IW{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            settle_cnt_r <= settle_cnt_s;
            lfsr_r       <= lfsr_s;
            mode_exh_r   <= mode_exh_s;
            stop_r       <= stop_s;
            num_vec_r    <= num_vec_s;
            vec_index_r  <= vec_index_s;
            vec_r        <= vec_s;
            flag_r       <= flag_s;
            count_r      <= count_s;
            ff_r         <= ff_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    assign vec_op         = vec_r[IW-1:IW-2];
    assign vec_a          = vec_r[2*WIDTH-1:WIDTH];
    assign vec_b          = vec_r[WIDTH-1:0];
    assign busy           = busy_r;
    assign done           = done_r;
    assign vec_index      = vec_index_r;
    assign mismatch_flag  = flag_r;
    assign mismatch_count = count_r;
    assign first_fail_op  = ff_r[IW-1:IW-2];
    assign first_fail_a   = ff_r[2*WIDTH-1:WIDTH];
    assign first_fail_b   = ff_r[WIDTH-1:0];

endmodule

// File: tb/tb_alu_compare_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_compare_sequencer
//
// Scoreboard bench for alu_compare_sequencer at WIDTH=4, SETTLE_CYCLES=1. A
// reference ALU and a DUT ALU sit in the bench. The DUT ALU can carry a
// Trojan: trojan=1 flips y bit 0 for op=3, a=A, b=5, and trojan=2 inverts
// the zero flag for vectors 0x000 and 0x3FF. The stimulus pushes expected
// end-of-run results (and expected random vectors) into queues. A monitor
// pops and compares them whenever the DUT presents a done pulse or a new
// vector.
// -----------------------------------------------------------------------------
module tb_alu_compare_sequencer;

    localparam int W  = 4;
    localparam int IW = 2 * W + 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           abort;
    logic           mode_exh;
    logic           stop_on_mismatch;
    logic [15:0]    num_vectors;
    logic [W-1:0]   vec_a;
    logic [W-1:0]   vec_b;
    logic [1:0]     vec_op;
    logic [W-1:0]   y_ref;
    logic           zero_ref;
    logic [W-1:0]   y_dut;
    logic           zero_dut;
    logic           busy;
    logic           done;
    logic [IW-1:0]  vec_index;
    logic           mismatch_flag;
    logic [15:0]    mismatch_count;
    logic [W-1:0]   first_fail_a;
    logic [W-1:0]   first_fail_b;
    logic [1:0]     first_fail_op;

    int   trojan = 0;
    logic cur_exh = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_seen = 0;
    int   vec_seen = 0;

    typedef struct {
        int          cycles;
        int          nvec;
        logic [15:0] count;
        logic        flag;
        logic [W-1:0] ff_a;
        logic [W-1:0] ff_b;
        logic [1:0]  ff_op;
        logic [IW-1:0] idx;
    } res_t;

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [IW-1:0] idx;
    } vec_t;

    res_t exp_q[$];
    vec_t vec_q[$];

    alu_compare_sequencer #(
        .WIDTH         (W),
        .SETTLE_CYCLES (1),
        .LFSR_SEED     (32'hACE1_2F3D)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .mode_exh         (mode_exh),
        .stop_on_mismatch (stop_on_mismatch),
        .num_vectors      (num_vectors),
        .vec_a            (vec_a),
        .vec_b            (vec_b),
        .vec_op           (vec_op),
        .y_ref            (y_ref),
        .zero_ref         (zero_ref),
        .y_dut            (y_dut),
        .zero_dut         (zero_dut),
        .busy             (busy),
        .done             (done),
        .vec_index        (vec_index),
        .mismatch_flag    (mismatch_flag),
        .mismatch_count   (mismatch_count),
        .first_fail_a     (first_fail_a),
        .first_fail_b     (first_fail_b),
        .first_fail_op    (first_fail_op)
    );

    always #5 clk = ~clk;

    // Reference ALU and the optionally Trojaned DUT ALU.
    always_comb begin
        case (vec_op)
            2'd0:    y_ref = vec_a + vec_b;
            2'd1:    y_ref = vec_a - vec_b;
            2'd2:    y_ref = vec_a & vec_b;
            default: y_ref = vec_a ^ vec_b;
        endcase
        zero_ref = (y_ref == 4'h0);
        y_dut    = y_ref;
        zero_dut = zero_ref;
        if (trojan == 1 && vec_op == 2'd3 && vec_a == 4'hA && vec_b == 4'h5) begin
            y_dut    = y_ref ^ 4'h1;
            zero_dut = (y_dut == 4'h0);
        end else if (trojan == 2 && ({vec_op, vec_a, vec_b} == 10'h000 ||
                                     {vec_op, vec_a, vec_b} == 10'h3FF)) begin
            zero_dut = ~zero_ref;
        end else begin
            y_dut = y_ref;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {15'd0, vec_a, vec_b, vec_op, busy, done, vec_index, mismatch_flag,
                mismatch_count, first_fail_a, first_fail_b, first_fail_op};
    endfunction

    // Monitor: samples 1 time unit after each rising edge, scores vectors and done pulses.
    initial begin
        logic          busy_prev = 1'b0;
        logic          done_prev = 1'b0;
        logic [IW-1:0] idx_prev  = '0;
        res_t r;
        vec_t v;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (busy && !busy_prev) vec_seen = 0;
            if (busy && !done && (!busy_prev || vec_index != idx_prev)) begin
                check("vec_index_step", 64'(vec_index), 64'(vec_seen));
                if (cur_exh) begin
                    check("exh_decode", 64'({vec_op, vec_a, vec_b}), 64'(vec_index));
                end else if (vec_q.size() > 0) begin
                    v = vec_q.pop_front();
                    check("rnd_vector", 64'({vec_op, vec_a, vec_b, vec_index}),
                          64'({v.op, v.a, v.b, v.idx}));
                end
                vec_seen = vec_seen + 1;
            end
            if (done) begin
                done_seen = done_seen + 1;
                check("done_single_cycle", 64'(done_prev), 64'd0);
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_done got done=1 expected no done at cycle %0d", cyc);
                end else begin
                    r = exp_q.pop_front();
                    check("done_latency", 64'(cyc - start_cyc + 1), 64'(r.cycles));
                    check("vectors_applied", 64'(vec_seen), 64'(r.nvec));
                    check("mismatch_count", 64'(mismatch_count), 64'(r.count));
                    check("mismatch_flag", 64'(mismatch_flag), 64'(r.flag));
                    check("first_fail", 64'({first_fail_op, first_fail_a, first_fail_b}),
                          64'({r.ff_op, r.ff_a, r.ff_b}));
                    check("final_index", 64'(vec_index), 64'(r.idx));
                end
            end
            busy_prev = busy;
            done_prev = done;
            idx_prev  = vec_index;
        end
    end

    task automatic push_res(input int cycles, input int nvec, input logic [15:0] count,
                            input logic flag, input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [IW-1:0] idx);
        res_t r;
        r.cycles = cycles; r.nvec = nvec; r.count = count; r.flag = flag;
        r.ff_op = op; r.ff_a = a; r.ff_b = b; r.idx = idx;
        exp_q.push_back(r);
    endtask

    // First four LFSR states from 32'hACE1_2F3D, worked by hand:
    // ACE12F3D, D650979D, EB084BCD, F5A425E5 -> {op, a=[3:0], b=[7:4]}.
    task automatic push_rnd4();
        vec_q.push_back('{2'd2, 4'hD, 4'h3, 10'd0});
        vec_q.push_back('{2'd3, 4'hD, 4'h9, 10'd1});
        vec_q.push_back('{2'd3, 4'hD, 4'hC, 10'd2});
        vec_q.push_back('{2'd3, 4'h5, 4'hE, 10'd3});
    endtask

    task automatic issue_start(input logic mexh, input logic stop, input logic [15:0] n,
                               input logic with_abort);
        @(negedge clk);
        mode_exh         = mexh;
        stop_on_mismatch = stop;
        num_vectors      = n;
        abort            = with_abort;
        start            = 1'b1;
        cur_exh          = mexh;
        start_cyc        = cyc;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n = n + 1;
        end
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL run_timeout got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check("idle_after_run", 64'({busy, done}), 64'd0);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        mode_exh = 1'b0; stop_on_mismatch = 1'b0; num_vectors = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_state", all_outs(), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_outputs", all_outs(), 64'd0);

        // Exhaustive clean vs clean: 1024 vectors.
        trojan = 0;
        push_res(3 * 1024 + 2, 1024, 16'd0, 1'b0, 2'd0, 4'h0, 4'h0, 10'h3FF);
        issue_start(1'b1, 1'b0, 16'd0, 1'b0);
        wait_drain(5000);

        // Exhaustive with y Trojan; a start pulse mid-run must be ignored.
        trojan = 1;
        push_res(3 * 1024 + 2, 1024, 16'd1, 1'b1, 2'd3, 4'hA, 4'h5, 10'h3FF);
        issue_start(1'b1, 1'b0, 16'd0, 1'b0);
        repeat (50) @(negedge clk);
        mode_exh = 1'b0; stop_on_mismatch = 1'b1; num_vectors = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain(5000);

        // Same Trojan with stop_on_mismatch: ends after CHECK of index 0x3A5.
        push_res(3 * 934 + 2, 934, 16'd1, 1'b1, 2'd3, 4'hA, 4'h5, 10'h3A5);
        issue_start(1'b1, 1'b1, 16'd0, 1'b0);
        wait_drain(5000);

        // Zero-flag-only Trojan at the first and last vectors.
        trojan = 2;
        push_res(3 * 1024 + 2, 1024, 16'd2, 1'b1, 2'd0, 4'h0, 4'h0, 10'h3FF);
        issue_start(1'b1, 1'b0, 16'd0, 1'b0);
        wait_drain(5000);

        // Random, zero vectors: straight to DONE, counters cleared.
        trojan = 0;
        push_res(2, 0, 16'd0, 1'b0, 2'd0, 4'h0, 4'h0, 10'h000);
        issue_start(1'b0, 1'b0, 16'd0, 1'b0);
        wait_drain(100);

        // Random, four vectors, with abort raised together with start (start wins).
        push_rnd4();
        push_res(14, 4, 16'd0, 1'b0, 2'd0, 4'h0, 4'h0, 10'd3);
        issue_start(1'b0, 1'b0, 16'd4, 1'b1);
        wait_drain(100);

        // Abort in CHECK of vector 0 while it mismatches: no result update.
        trojan = 2;
        d0 = done_seen;
        issue_start(1'b1, 1'b0, 16'd0, 1'b0);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_check_busy", 64'(busy), 64'd0);
        check("abort_check_count", 64'({mismatch_flag, mismatch_count}), 64'd0);

        // Abort in SETTLE of vector 5 after a mismatch on vector 0.
        issue_start(1'b1, 1'b0, 16'd0, 1'b0);
        repeat (16) @(negedge clk);
        check("abort_settle_index", 64'(vec_index), 64'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_settle_busy", 64'(busy), 64'd0);
        check("abort_hold_count", 64'({mismatch_flag, mismatch_count}), 64'h1_0001);
        check("abort_hold_index", 64'(vec_index), 64'd5);
        repeat (10) @(negedge clk);
        check("abort_no_done", 64'(done_seen), 64'(d0));

        // A following start clears counters and restarts at index 0.
        trojan = 0;
        push_rnd4();
        push_res(14, 4, 16'd0, 1'b0, 2'd0, 4'h0, 4'h0, 10'd3);
        issue_start(1'b0, 1'b0, 16'd4, 1'b0);
        wait_drain(100);

        // Asynchronous reset between clock edges in the middle of a Trojan run.
        trojan = 1;
        d0 = done_seen;
        issue_start(1'b1, 1'b0, 16'd0, 1'b0);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_no_done", 64'(done_seen), 64'(d0));

        // Fresh run after reset reproduces the same random sequence.
        trojan = 0;
        push_rnd4();
        push_res(14, 4, 16'd0, 1'b0, 2'd0, 4'h0, 4'h0, 10'd3);
        issue_start(1'b0, 1'b0, 16'd4, 1'b0);
        wait_drain(100);

        check("pending_vectors", 64'(vec_q.size()), 64'd0);
        check("total_done_pulses", 64'(done_seen), 64'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_compare_sequencer.md
Name: alu_compare_sequencer

Overview:
Self-checking vector sequencer that drives one operand/opcode stream into two WIDTH-bit ALUs in lockstep: a reference ALU and a device under test. It compares their result and zero outputs and logs mismatches. It is the clocked replacement for hand-written compare benches and the run-time Trojan-detection harness around the ALU pair. Vectors come from an exhaustive sweep or from a 32-bit LFSR.

Parameters:
WIDTH, 8, ALU operand width; 2 to 15 (random mode needs 2*WIDTH <= 30).
SETTLE_CYCLES, 1, cycles between applying a vector and sampling the ALU outputs; minimum 1.
LFSR_SEED, 32'hACE1_2F3D, random-mode seed; must be non-zero.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  terminate a run; sampled in APPLY, SETTLE and CHECK
mode_exh  in  1  1 = exhaustive sweep, 0 = LFSR random; latched at start
stop_on_mismatch  in  1  end the run at the first mismatch; latched at start
num_vectors  in  16  random-mode vector count; latched at start
vec_a  out  WIDTH  operand a to both ALUs
vec_b  out  WIDTH  operand b to both ALUs
vec_op  out  2  opcode to both ALUs
y_ref  in  WIDTH  reference ALU result
zero_ref  in  1  reference ALU zero flag
y_dut  in  WIDTH  DUT ALU result
zero_dut  in  1  DUT ALU zero flag
busy  out  1  high in APPLY, SETTLE, CHECK and DONE
done  out  1  one-cycle pulse in DONE
vec_index  out  2*WIDTH+2  index of the vector currently applied
mismatch_flag  out  1  sticky; a mismatch was seen this run
mismatch_count  out  16  mismatches this run; saturates at 16'hFFFF
first_fail_a  out  WIDTH  vec_a of the first mismatch
first_fail_b  out  WIDTH  vec_b of the first mismatch
first_fail_op  out  2  vec_op of the first mismatch

Behaviour:
- Reset: rst_n low forces IDLE immediately. All outputs go to 0 and the LFSR reloads LFSR_SEED. Reset mid-run discards the run and no done pulse is produced.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 latches mode_exh, stop_on_mismatch and num_vectors.
  - It also clears mismatch_flag, mismatch_count, first_fail_* and vec_index, and reloads the LFSR with the seed.
  - Random mode with num_vectors=0 goes straight to DONE with no vectors applied.
  - Otherwise the FSM loads vector 0 and goes to APPLY.
- APPLY: lasts 1 cycle; vector outputs are stable. Next state is SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles, then goes to CHECK.
- CHECK: lasts 1 cycle and samples the ALU outputs.
  - Mismatch means (y_ref != y_dut) or (zero_ref != zero_dut).
  - On mismatch: mismatch_count increments (saturating) and mismatch_flag sets.
  - If mismatch_flag was 0 before this cycle, first_fail_* capture the current vec_*.
  - Go to DONE if this is the last vector, or if stop_on_mismatch is set and a mismatch occurred.
  - Otherwise vec_index increments, the next vector loads, and the FSM goes to APPLY.
- Per-vector cost: 2+SETTLE_CYCLES cycles.
- DONE: lasts 1 cycle with done=1, then IDLE. Results hold until the next start.
- Exhaustive vector k:
  - {vec_op, vec_a, vec_b} = k[2W+1:2W], k[2W-1:W], k[W-1:0].
  - The last vector is k = all ones.
  - vec_index wraps to 0 only by the run ending; it never increments past all ones.
- Random vector k is the LFSR state after k steps from the seed:
  - vec_op = lfsr[31:30], vec_a = lfsr[W-1:0], vec_b = lfsr[2W-1:W].
  - The LFSR is a Galois shifter with polynomial x^32+x^22+x^2+x+1, stepped once per vector advance.
  - The last vector is index num_vectors-1.
- abort=1 in APPLY, SETTLE or CHECK returns the FSM to IDLE next cycle with no done pulse; captured results hold.
  - abort has priority over CHECK's result update.
- start is ignored while busy. start and abort arriving together in IDLE: start wins and abort is ignored.
- vec_* are registered outputs and change only on entry to APPLY.

Test Plan:
1. Exhaustive run, WIDTH=8, SETTLE_CYCLES=1, clean ALU vs clean ALU -> done 3*262144+2 cycles after start; mismatch_count=0; mismatch_flag=0.
2. Exhaustive run, clean vs Trojan ALU (trigger op=11, a=A5, b=5A) -> mismatch_count=1; first_fail_op=3, first_fail_a=A5, first_fail_b=5A; done pulses exactly once.
3. Scenario 2 with stop_on_mismatch=1 -> done follows the CHECK of vec_index=0x3A55A; mismatch_count=1.
4. Random mode, num_vectors=0 -> done one cycle after leaving IDLE; count=0. num_vectors=4 -> vec_* match the first four LFSR states from the seed; done at cycle 14.
5. Abort during SETTLE of vector 5 -> IDLE next cycle; no done pulse; busy=0. A following start clears the counters and restarts at index 0.
6. rst_n low mid-run (also asserted asynchronously, between clock edges) -> outputs are 0 immediately. A start after release runs the same sequence as a fresh run.
